pixel_color_matrix: RTL and testbench

- Streaming per-pixel RGB colour-matrix filter; generalises the sepia transform to selectable modes (bypass, grayscale, sepia, programmable 3x3 matrix).
- Signed fixed-point coefficients with rounding and saturation.
- Sits between the image reader and the image writer: valid/ready pixel stream in and out, with frame sideband and frame-completion tracking.

---
 rtl/pixel_pkg.sv | 36 +++
 rtl/cm_row_mac.sv | 76 +++++++
 rtl/pixel_color_matrix.sv | 212 +++++++++++++++++++++
 tb/tb_pixel_color_matrix.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel colour-matrix filter.
//   - default widths for pixel components, coefficients and image dimensions
//   - colour mode encoding
//   - fixed Q2.10 coefficient banks, row-major (row = output R,G,B; column = input R,G,B)
package pixel_pkg;

  localparam int unsigned PIX_W_DEFAULT  = 8;
  localparam int unsigned COEF_W_DEFAULT = 12;
  localparam int unsigned FRAC_DEFAULT   = 10;
  localparam int unsigned DIM_W_DEFAULT  = 12;

  localparam int unsigned NUM_COEF = 9;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_GRAY   = 2'd1,
    MODE_SEPIA  = 2'd2,
    MODE_CUSTOM = 2'd3
  } pixMode_t;

  typedef logic signed [COEF_W_DEFAULT-1:0] coef_t;
  typedef coef_t coefBank_t [NUM_COEF];

  localparam int IDENTITY_BANK [NUM_COEF] = '{1024,    0,    0,
                                                 0, 1024,    0,
                                                 0,    0, 1024};

  localparam int SEPIA_BANK [NUM_COEF] = '{402, 787, 194,
                                           357, 702, 172,
                                           279, 547, 134};

  localparam int GRAY_BANK [NUM_COEF] = '{306, 601, 117,
                                          306, 601, 117,
                                          306, 601, 117};

endpackage

// File: rtl/cm_row_mac.sv
// One output row of the colour matrix: three signed multiplies, sum with
// half-LSB rounding, arithmetic shift and clamp to the pixel range.
// Three register stages (products, rounded sum, clamped pixel) share one
// stall enable so all rows of the matrix move in lock-step.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   en                        advance the pipeline
//   inR, inG, inB             unsigned input components
//   coefR, coefG, coefB       signed Q(x).FRAC coefficients for this row
//   outPix                    clamped output component (valid 3 enables later)
module cm_row_mac #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned COEF_W = 12,
  parameter int unsigned FRAC   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [PIX_W-1:0]  inR,
  input  logic [PIX_W-1:0]  inG,
  input  logic [PIX_W-1:0]  inB,
  input  logic [COEF_W-1:0] coefR,
  input  logic [COEF_W-1:0] coefG,
  input  logic [COEF_W-1:0] coefB,
  output logic [PIX_W-1:0]  outPix
);

  localparam int unsigned PROD_W = PIX_W + COEF_W + 1;
  // Three products of PROD_W bits plus the rounding term cannot overflow this.
  localparam int unsigned SUM_W  = PIX_W + COEF_W + 3;
  localparam logic signed [SUM_W-1:0] ROUND_HALF = SUM_W'(1) <<< (FRAC - 1);

  logic signed [PROD_W-1:0] prodRD, prodGD, prodBD;
  logic signed [PROD_W-1:0] prodRQ, prodGQ, prodBQ;
  logic signed [SUM_W-1:0]  sumD, sumQ;
  logic signed [SUM_W-1:0]  shifted;
  logic [PIX_W-1:0]         pixD;

  // Pixels are unsigned: zero-extend by one bit before the signed multiply.
  always_comb begin
    prodRD = $signed({1'b0, inR}) * $signed(coefR);
    prodGD = $signed({1'b0, inG}) * $signed(coefG);
    prodBD = $signed({1'b0, inB}) * $signed(coefB);
  end

  always_comb begin
    sumD = SUM_W'(prodRQ) + SUM_W'(prodGQ) + SUM_W'(prodBQ) + ROUND_HALF;
  end

  always_comb begin
    shifted = sumQ >>> FRAC;
    pixD    = shifted[PIX_W-1:0];
    if (shifted[SUM_W-1]) begin
      pixD = '0;
    end else if (|shifted[SUM_W-2:PIX_W]) begin
      pixD = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prodRQ <= '0;
      prodGQ <= '0;
      prodBQ <= '0;
      sumQ   <= '0;
      outPix <= '0;
    end else if (en) begin
      prodRQ <= prodRD;
      prodGQ <= prodGD;
      prodBQ <= prodBD;
      sumQ   <= sumD;
      outPix <= pixD;
    end
  end

endmodule

// File: rtl/pixel_color_matrix.sv
// Streaming RGB colour-matrix filter (bypass, grayscale, sepia, custom 3x3).
// Three-stage pipeline with a single global stall; frame sideband travels with
// each pixel and the output side counts pixels to flag end-of-frame.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mode                          0 bypass, 1 grayscale, 2 sepia, 3 custom
//   img_w, img_h                  frame dimensions (0 in either = never done)
//   cfg_we, cfg_addr, cfg_data    write one custom coefficient (index 0..8)
//   in_valid, in_ready, in_sof    input handshake and first-pixel flag
//   in_r, in_g, in_b              input components
//   out_valid, out_ready          output handshake
//   out_sof, out_eof              frame flags aligned with the output pixel
//   out_r, out_g, out_b           output components
//   frame_done                    pulse on the last-pixel output handshake
//   frame_err                     sticky: sof seen while a frame was in progress
module pixel_color_matrix
  import pixel_pkg::*;
#(
  parameter int unsigned PIX_W  = PIX_W_DEFAULT,
  parameter int unsigned COEF_W = COEF_W_DEFAULT,
  parameter int unsigned FRAC   = FRAC_DEFAULT,
  parameter int unsigned DIM_W  = DIM_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [COEF_W-1:0] cfg_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [PIX_W-1:0]  in_r,
  input  logic [PIX_W-1:0]  in_g,
  input  logic [PIX_W-1:0]  in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eof,
  output logic [PIX_W-1:0]  out_r,
  output logic [PIX_W-1:0]  out_g,
  output logic [PIX_W-1:0]  out_b,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int unsigned CNT_W = 2 * DIM_W;

  logic adv, accept, loadBank, outHs;

  logic [COEF_W-1:0] stageBank  [NUM_COEF];
  logic [COEF_W-1:0] activeBank [NUM_COEF];
  logic [COEF_W-1:0] newBank    [NUM_COEF];
  logic [COEF_W-1:0] useBank    [NUM_COEF];

  logic [2:0] validQ, sofQ;

  logic [CNT_W-1:0] countD, countQ;
  logic [CNT_W-1:0] total, lastIdx;
  logic             dimsOk, isLast;
  logic             errD, errQ;

  // Bubbles are not squeezed out: the whole pipe either moves or freezes.
  assign adv      = !validQ[2] || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;
  assign loadBank = accept && in_sof;

  always_comb begin
    for (int i = 0; i < NUM_COEF; i++) begin
      newBank[i] = stageBank[i];
      unique case (pixMode_t'(mode))
        MODE_BYPASS: newBank[i] = COEF_W'(IDENTITY_BANK[i]);
        MODE_GRAY:   newBank[i] = COEF_W'(GRAY_BANK[i]);
        MODE_SEPIA:  newBank[i] = COEF_W'(SEPIA_BANK[i]);
        MODE_CUSTOM: newBank[i] = stageBank[i];
      endcase
    end
  end

  // The sof pixel itself is processed with the bank it is about to latch.
  always_comb begin
    for (int i = 0; i < NUM_COEF; i++) begin
      useBank[i] = loadBank ? newBank[i] : activeBank[i];
    end
  end

  // A write coinciding with a bank load only reaches staging; the load sees
  // the pre-write value because both sample the same old register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        stageBank[i]  <= COEF_W'(IDENTITY_BANK[i]);
        activeBank[i] <= COEF_W'(IDENTITY_BANK[i]);
      end
    end else begin
      if (cfg_we && (cfg_addr < 4'(NUM_COEF))) begin
        stageBank[cfg_addr] <= cfg_data;
      end
      if (loadBank) begin
        for (int i = 0; i < NUM_COEF; i++) begin
          activeBank[i] <= newBank[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      validQ <= '0;
      sofQ   <= '0;
    end else if (adv) begin
      validQ <= {validQ[1:0], in_valid};
      sofQ   <= {sofQ[1:0], in_valid && in_sof};
    end
  end

  cm_row_mac #(
    .PIX_W  (PIX_W),
    .COEF_W (COEF_W),
    .FRAC   (FRAC)
  ) u_rowR (
    .clk    (clk),
    .rst    (rst),
    .en     (adv),
    .inR    (in_r),
    .inG    (in_g),
    .inB    (in_b),
    .coefR  (useBank[0]),
    .coefG  (useBank[1]),
    .coefB  (useBank[2]),
    .outPix (out_r)
  );

  cm_row_mac #(
    .PIX_W  (PIX_W),
    .COEF_W (COEF_W),
    .FRAC   (FRAC)
  ) u_rowG (
    .clk    (clk),
    .rst    (rst),
    .en     (adv),
    .inR    (in_r),
    .inG    (in_g),
    .inB    (in_b),
    .coefR  (useBank[3]),
    .coefG  (useBank[4]),
    .coefB  (useBank[5]),
    .outPix (out_g)
  );

  cm_row_mac #(
    .PIX_W  (PIX_W),
    .COEF_W (COEF_W),
    .FRAC   (FRAC)
  ) u_rowB (
    .clk    (clk),
    .rst    (rst),
    .en     (adv),
    .inR    (in_r),
    .inG    (in_g),
    .inB    (in_b),
    .coefR  (useBank[6]),
    .coefG  (useBank[7]),
    .coefB  (useBank[8]),
    .outPix (out_b)
  );

  assign out_valid = validQ[2];
  assign out_sof   = sofQ[2];
  assign outHs     = validQ[2] && out_ready;

  assign total   = CNT_W'(img_w) * CNT_W'(img_h);
  assign lastIdx = total - CNT_W'(1);
  assign dimsOk  = (img_w != '0) && (img_h != '0);
  assign isLast  = dimsOk && (countQ == lastIdx);

  assign out_eof    = validQ[2] && isLast;
  assign frame_done = outHs && isLast;
  assign frame_err  = errQ;

  // Completion wins over a restart so single-pixel frames still finish.
  always_comb begin
    countD = countQ;
    errD   = errQ;
    if (outHs) begin
      if (isLast) begin
        countD = '0;
      end else if (sofQ[2]) begin
        countD = CNT_W'(1);
      end else begin
        countD = countQ + CNT_W'(1);
      end
      if (sofQ[2] && (countQ != '0)) begin
        errD = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      countQ <= '0;
      errQ   <= 1'b0;
    end else begin
      countQ <= countD;
      errQ   <= errD;
    end
  end

endmodule

// File: tb/tb_pixel_color_matrix.sv
// Directed self-checking bench for pixel_color_matrix: a table of single-pixel
// frames per mode, then hand-written sequences for custom coefficients,
// backpressure, mid-frame sof and reset with pixels in flight.
module tb_pixel_color_matrix;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic [11:0] img_w, img_h;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [11:0] cfg_data;
  logic        in_valid, in_ready, in_sof;
  logic [7:0]  in_r, in_g, in_b;
  logic        out_valid, out_ready, out_sof, out_eof;
  logic [7:0]  out_r, out_g, out_b;
  logic        frame_done, frame_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] r, g, b;
    logic [7:0] er, eg, eb;
  } vec_t;

  typedef struct {
    logic [7:0] r, g, b;
    logic       sof, eof, done;
  } obs_t;

  obs_t outQ[$];
  vec_t vecs[5];

  pixel_color_matrix dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .img_w      (img_w),
    .img_h      (img_h),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sof     (in_sof),
    .in_r       (in_r),
    .in_g       (in_g),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .out_r      (out_r),
    .out_g      (out_g),
    .out_b      (out_b),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every output handshake as seen at the clock edge.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      outQ.push_back('{out_r, out_g, out_b, out_sof, out_eof, frame_done});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic popCheck(input string tag, input int er, input int eg, input int eb,
                          input int es, input int ee, input int ed);
    obs_t o;
    if (outQ.size() == 0) begin
      check({tag, " present"}, 0, 1);
      return;
    end
    o = outQ.pop_front();
    check({tag, " r"}, o.r, er);
    check({tag, " g"}, o.g, eg);
    check({tag, " b"}, o.b, eb);
    check({tag, " sof"}, o.sof, es);
    check({tag, " eof"}, o.eof, ee);
    check({tag, " done"}, o.done, ed);
  endtask

  task automatic sendPix(input logic sof, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b);
    in_valid = 1'b1;
    in_sof   = sof;
    in_r     = r;
    in_g     = g;
    in_b     = b;
    tick();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic cfgWrite(input logic [3:0] addr, input logic [11:0] data);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic waitOut(input int n, input string tag);
    int k = 0;
    while (outQ.size() < n && k < 50) begin
      tick();
      k++;
    end
    if (outQ.size() < n) check({tag, " timeout outputs"}, outQ.size(), n);
  endtask

  initial begin
    int lat;

    vecs[0] = '{2'd2, 8'd100, 8'd150, 8'd200, 8'd192, 8'd171, 8'd134};
    vecs[1] = '{2'd2, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd239};
    vecs[2] = '{2'd1, 8'd100, 8'd150, 8'd200, 8'd141, 8'd141, 8'd141};
    vecs[3] = '{2'd0, 8'd17,  8'd0,   8'd255, 8'd17,  8'd0,   8'd255};
    // Custom mode with the reset (identity) staging bank.
    vecs[4] = '{2'd3, 8'd10,  8'd20,  8'd30,  8'd10,  8'd20,  8'd30};

    rst = 1'b1; mode = 2'd0; img_w = 12'd1; img_h = 12'd1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_sof = 1'b0; in_r = '0; in_g = '0; in_b = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("reset out_r", out_r, 0);
    check("reset out_eof", out_eof, 0);
    check("reset frame_done", frame_done, 0);
    check("reset frame_err", frame_err, 0);
    rst = 1'b0;
    tick();

    // Single-pixel frames: latency, values and all frame flags.
    for (int i = 0; i < 5; i++) begin
      mode = vecs[i].mode;
      sendPix(1'b1, vecs[i].r, vecs[i].g, vecs[i].b);
      lat = 1;
      while (!out_valid && lat < 10) begin
        tick();
        lat++;
      end
      check($sformatf("vec%0d latency", i), lat, 3);
      tick();
      popCheck($sformatf("vec%0d", i), vecs[i].er, vecs[i].eg, vecs[i].eb, 1, 1, 1);
    end

    // Custom bank; 2047 is the largest coefficient below 2.0 in Q2.10.
    cfgWrite(4'd0, 12'hC00);
    cfgWrite(4'd4, 12'd2047);
    mode = 2'd3; img_w = 12'd2; img_h = 12'd1;
    sendPix(1'b1, 8'd50, 8'd100, 8'd7);
    cfgWrite(4'd4, 12'd1024);
    mode = 2'd0;
    sendPix(1'b0, 8'd50, 8'd100, 8'd7);
    waitOut(2, "custom");
    popCheck("custom sof", 0, 200, 7, 1, 0, 0);
    popCheck("custom midframe", 0, 200, 7, 0, 1, 1);

    // Write and sof in the same cycle: the sof copies the old addr0 value.
    mode = 2'd3; img_w = 12'd1; img_h = 12'd1;
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 12'd1024;
    sendPix(1'b1, 8'd50, 8'd100, 8'd7);
    cfg_we = 1'b0;
    sendPix(1'b1, 8'd50, 8'd100, 8'd7);
    waitOut(2, "simul");
    popCheck("simul write", 0, 100, 7, 1, 1, 1);
    popCheck("next frame", 50, 100, 7, 1, 1, 1);

    // Backpressure: freeze with three pixels in the pipe and one waiting.
    mode = 2'd0; img_w = 12'd4; img_h = 12'd1; out_ready = 1'b0;
    sendPix(1'b1, 8'd1, 8'd2, 8'd3);
    sendPix(1'b0, 8'd4, 8'd5, 8'd6);
    sendPix(1'b0, 8'd7, 8'd8, 8'd9);
    in_valid = 1'b1; in_sof = 1'b0; in_r = 8'd10; in_g = 8'd11; in_b = 8'd12;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d out_valid", k), out_valid, 1);
      check($sformatf("stall%0d in_ready", k), in_ready, 0);
      check($sformatf("stall%0d out_r", k), out_r, 1);
      check($sformatf("stall%0d out_sof", k), out_sof, 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    waitOut(4, "backpressure");
    popCheck("bp px0", 1, 2, 3, 1, 0, 0);
    popCheck("bp px1", 4, 5, 6, 0, 0, 0);
    popCheck("bp px2", 7, 8, 9, 0, 0, 0);
    popCheck("bp px3", 10, 11, 12, 0, 1, 1);
    tick();
    tick();
    check("bp no duplicate", outQ.size(), 0);

    // Sof at pixel 2 of a 4-pixel frame restarts the count.
    check("pre err frame_err", frame_err, 0);
    for (int i = 0; i < 6; i++) begin
      sendPix((i == 0) || (i == 2), 8'(i * 10), 8'(i * 10 + 1), 8'(i * 10 + 2));
    end
    waitOut(6, "midsof");
    for (int i = 0; i < 6; i++) begin
      popCheck($sformatf("midsof px%0d", i), i * 10, i * 10 + 1, i * 10 + 2,
               ((i == 0) || (i == 2)) ? 1 : 0, (i == 5) ? 1 : 0, (i == 5) ? 1 : 0);
    end
    check("frame_err set", frame_err, 1);
    tick();
    tick();
    check("frame_err sticky", frame_err, 1);

    // Reset with one pixel already out (count 1) and two in flight.
    mode = 2'd0; img_w = 12'd4; img_h = 12'd1;
    sendPix(1'b1, 8'd1, 8'd1, 8'd1);
    sendPix(1'b0, 8'd2, 8'd2, 8'd2);
    sendPix(1'b0, 8'd3, 8'd3, 8'd3);
    tick();
    rst = 1'b1;
    tick();
    check("rst out_valid", out_valid, 0);
    check("rst in_ready", in_ready, 1);
    check("rst out_r", out_r, 0);
    check("rst frame_done", frame_done, 0);
    check("rst frame_err", frame_err, 0);
    rst = 1'b0;
    outQ.delete();
    for (int k = 0; k < 5; k++) tick();
    check("rst dropped in-flight", outQ.size(), 0);

    // Non-sof pixels after reset use the bypass bank and a zeroed counter.
    mode = 2'd2; img_w = 12'd2; img_h = 12'd1;
    sendPix(1'b0, 8'd100, 8'd150, 8'd200);
    sendPix(1'b0, 8'd1, 8'd2, 8'd3);
    waitOut(2, "post rst");
    popCheck("post rst px0", 100, 150, 200, 0, 0, 0);
    popCheck("post rst px1", 1, 2, 3, 0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
